// File: rtl/sc_ram_pkg.sv
// ---------------------------------------------------------------------------
// sc_ram_pkg
//   Shared types and constants for the dual-port block RAM with a pipelined
//   read path.
//   - ram_state_e      : controller state (CLEAR while zeroing, READY after)
//   - MIN/MAX_READ_LATENCY : legal range of the read delay line
//   - BYTE_WIDTH       : granularity of the write byte enables
// ---------------------------------------------------------------------------
package sc_ram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } ram_state_e;

  localparam int MIN_READ_LATENCY = 1;
  localparam int MAX_READ_LATENCY = 3;
  localparam int BYTE_WIDTH       = 8;

endpackage

// File: rtl/sc_ram_rd_pipe.sv
// ---------------------------------------------------------------------------
// sc_ram_rd_pipe
//   Fixed-length delay line carrying read-valid and read-data from the array
//   to the output. Valid bits are reset; data bits are not, so the first
//   stage can be absorbed into a block-RAM output register.
//   Ports:
//     clk_i     : clock
//     rst_i     : asynchronous active-high reset (clears valid bits only)
//     in_valid  : a read was accepted this cycle
//     in_data   : word read from the array this cycle
//     out_valid : delayed valid, STAGES cycles later
//     out_data  : delayed data, forced to zero whenever out_valid is low
// ---------------------------------------------------------------------------
module sc_ram_rd_pipe
  import sc_ram_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int STAGES     = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data
);

  if (STAGES < MIN_READ_LATENCY || STAGES > MAX_READ_LATENCY) begin : g_bad_stages
    $error("sc_ram_rd_pipe: STAGES=%0d outside legal range", STAGES);
  end

  logic [STAGES-1:0]     valid_q;
  logic [DATA_WIDTH-1:0] data_q [STAGES];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
    end else begin
      valid_q[0] <= in_valid;
      for (int s = 1; s < STAGES; s++) begin
        valid_q[s] <= valid_q[s-1];
      end
    end
  end

  // Data advances every cycle regardless of valid; the output mask below
  // hides whatever garbage travels alongside an invalid slot.
  always_ff @(posedge clk_i) begin
    data_q[0] <= in_data;
    for (int s = 1; s < STAGES; s++) begin
      data_q[s] <= data_q[s-1];
    end
  end

  assign out_valid = valid_q[STAGES-1];
  assign out_data  = out_valid ? data_q[STAGES-1] : '0;

endmodule

// File: rtl/sc_dual_block_ram_pipe.sv
// ---------------------------------------------------------------------------
// sc_dual_block_ram_pipe
//   Simple dual-port RAM (one write port, one read port, one clock) with
//   per-byte write enables, a configurable read latency and an optional
//   self-clear of the whole array after reset.
//   Ports:
//     clk_i            : clock
//     rst_i            : asynchronous active-high reset
//     wr_data_i        : write data
//     wr_address_i     : write address
//     wr_enable_i      : write strobe
//     wr_byte_enable_i : per-byte write mask, bit i covers bits [8i+7:8i]
//     rd_address_i     : read address
//     rd_enable_i      : read strobe
//     rd_data_o        : read data, zero unless rd_valid_o
//     rd_valid_o       : read data valid, READ_LATENCY cycles after accept
//     ready_o          : array usable (clear sequence finished)
// ---------------------------------------------------------------------------
module sc_dual_block_ram_pipe
  import sc_ram_pkg::*;
#(
  parameter int    DATA_WIDTH     = 32,
  parameter int    ADDRESS_WIDTH  = 8,
  parameter int    READ_LATENCY   = 1,
  parameter int    WRITE_FIRST    = 0,
  parameter int    CLEAR_ON_RESET = 1,
  parameter string INIT_FILE_NAME = ""
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [DATA_WIDTH-1:0]      wr_data_i,
  input  logic [ADDRESS_WIDTH-1:0]   wr_address_i,
  input  logic                       wr_enable_i,
  input  logic [DATA_WIDTH/8-1:0]    wr_byte_enable_i,
  input  logic [ADDRESS_WIDTH-1:0]   rd_address_i,
  input  logic                       rd_enable_i,
  output logic [DATA_WIDTH-1:0]      rd_data_o,
  output logic                       rd_valid_o,
  output logic                       ready_o
);

  localparam int DEPTH  = 1 << ADDRESS_WIDTH;
  localparam int NBYTES = DATA_WIDTH / BYTE_WIDTH;
  localparam ram_state_e RESET_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : READY;

  if (DATA_WIDTH < BYTE_WIDTH || (DATA_WIDTH % BYTE_WIDTH) != 0) begin : g_bad_dw
    $error("sc_dual_block_ram_pipe: DATA_WIDTH=%0d must be a multiple of 8, at least 8", DATA_WIDTH);
  end
  if (ADDRESS_WIDTH < 1 || ADDRESS_WIDTH > 16) begin : g_bad_aw
    $error("sc_dual_block_ram_pipe: ADDRESS_WIDTH=%0d outside 1..16", ADDRESS_WIDTH);
  end
  if (READ_LATENCY < MIN_READ_LATENCY || READ_LATENCY > MAX_READ_LATENCY) begin : g_bad_rl
    $error("sc_dual_block_ram_pipe: READ_LATENCY=%0d outside legal range", READ_LATENCY);
  end
  if (WRITE_FIRST != 0 && WRITE_FIRST != 1) begin : g_bad_wf
    $error("sc_dual_block_ram_pipe: WRITE_FIRST must be 0 or 1");
  end
  if (CLEAR_ON_RESET != 0 && CLEAR_ON_RESET != 1) begin : g_bad_cor
    $error("sc_dual_block_ram_pipe: CLEAR_ON_RESET must be 0 or 1");
  end

  ram_state_e               state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] clr_cnt_q, clr_cnt_d;

  logic [DATA_WIDTH-1:0]    mem [DEPTH];

  logic                     array_ready;
  logic                     wr_accept;
  logic                     rd_accept;
  logic                     mem_we;
  logic [ADDRESS_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0]    mem_wdata;
  logic [NBYTES-1:0]        mem_wbe;
  logic [DATA_WIDTH-1:0]    rd_word;

  // Gating with rst_i keeps ready_o low during reset even when the reset
  // state is already READY (no-clear configuration).
  assign array_ready = (state_q == READY) && !rst_i;
  assign ready_o     = array_ready;
  assign wr_accept   = wr_enable_i && array_ready;
  assign rd_accept   = rd_enable_i && array_ready;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= RESET_STATE;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // The counter stops on the last address instead of wrapping, so READY is
  // only left through a reset.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      CLEAR: begin
        if (&clr_cnt_q) begin
          state_d = READY;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      READY:   state_d = READY;
      default: state_d = RESET_STATE;
    endcase
  end

  // Single write port shared between the clear engine and the user.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = wr_address_i;
    mem_wdata = wr_data_i;
    mem_wbe   = wr_byte_enable_i;
    if (state_q == CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = clr_cnt_q;
      mem_wdata = '0;
      mem_wbe   = '1;
    end else if (wr_accept) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (mem_wbe[b]) begin
          mem[mem_waddr][b*BYTE_WIDTH +: BYTE_WIDTH] <= mem_wdata[b*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  // The array read sees the pre-write word; write-first mode overlays the
  // enabled bytes of a same-address write to return the merged word.
  always_comb begin
    rd_word = mem[rd_address_i];
    if ((WRITE_FIRST != 0) && wr_accept && (wr_address_i == rd_address_i)) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (wr_byte_enable_i[b]) begin
          rd_word[b*BYTE_WIDTH +: BYTE_WIDTH] = wr_data_i[b*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  sc_ram_rd_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .STAGES     (READ_LATENCY)
  ) u_rd_pipe (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .in_valid  (rd_accept),
    .in_data   (rd_word),
    .out_valid (rd_valid_o),
    .out_data  (rd_data_o)
  );

endmodule

// File: doc/sc_dual_block_ram_pipe.md
SC_DUAL_BLOCK_RAM_PIPE -- requirements
Module: sc_dual_block_ram_pipe

Interface
REQ-001 SHALL have parameter DATA_WIDTH, 32, word width in bits; a multiple of 8, at least 8.
REQ-002 SHALL have parameter ADDRESS_WIDTH, 8, address bits; DEPTH = 2**ADDRESS_WIDTH; legal range 1..16.
REQ-003 SHALL have parameter READ_LATENCY, 1, cycles from rd_enable_i to rd_valid_o; legal range 1..3.
REQ-004 SHALL have parameter WRITE_FIRST, 0, same-cycle same-address collision mode: 1 = new data, 0 = old data.
REQ-005 SHALL have parameter CLEAR_ON_RESET, 1, 1 = zero the whole array after every reset.
REQ-006 SHALL have parameter INIT_FILE_NAME, "", hex preload file; ignored when empty.
REQ-007 SHALL use one clock and an asynchronous, active-high reset.
REQ-008 clk_i  in  1  clock.
REQ-009 rst_i  in  1  asynchronous active-high reset.
REQ-010 wr_data_i  in  DATA_WIDTH  write data.
REQ-011 wr_address_i  in  ADDRESS_WIDTH  write address.
REQ-012 wr_enable_i  in  1  write strobe.
REQ-013 wr_byte_enable_i  in  DATA_WIDTH/8  per-byte write mask; bit i covers bits [8i+7:8i].
REQ-014 rd_address_i  in  ADDRESS_WIDTH  read address.
REQ-015 rd_enable_i  in  1  read strobe.
REQ-016 rd_data_o  out  DATA_WIDTH  read data, qualified by rd_valid_o.
REQ-017 rd_valid_o  out  1  read data valid.
REQ-018 ready_o  out  1  array ready; clear sequence complete.

Function
REQ-019 SHALL have FSM states CLEAR and READY; after reset the state is CLEAR if CLEAR_ON_RESET=1, else READY.
REQ-020 In CLEAR, SHALL write all-zero to address clr_cnt (starting at 0, +1 per cycle); on the write to DEPTH-1 it SHALL move to READY. The clear takes exactly DEPTH cycles.
REQ-021 ready_o SHALL be 1 only in READY; with CLEAR_ON_RESET=1 it SHALL first be high DEPTH cycles after reset release.
REQ-022 While ready_o=0, wr_enable_i and rd_enable_i SHALL be ignored: no user write, and no valid launched.
REQ-023 A write SHALL update only the bytes whose wr_byte_enable_i bit is 1, at the clock edge where wr_enable_i=1.
REQ-024 A read accepted at edge N SHALL produce rd_valid_o=1 and the data in the cycle after edge N+READ_LATENCY-1; it is fully pipelined, one read per cycle.
REQ-025 rd_data_o SHALL be all-zero whenever rd_valid_o=0.
REQ-026 For a read and write to the same address in the same cycle: WRITE_FIRST=1 SHALL return the merged word (new enabled bytes, old other bytes); WRITE_FIRST=0 SHALL return the pre-write word.
REQ-027 A read issued any cycle after a write SHALL return the written data, regardless of READ_LATENCY.
REQ-028 Simultaneous read and write to different addresses SHALL both complete with no interaction.
REQ-029 The address counter SHALL not wrap back into CLEAR; it SHALL hold until the next reset.

Reset
REQ-030 On rst_i assertion, SHALL asynchronously force: rd_valid_o=0, rd_data_o=0, ready_o=0, all valid pipeline stages=0, clr_cnt=0, state=reset state.
REQ-031 Reset mid-read SHALL drop all in-flight reads, with no valid returned after release.
REQ-032 Reset mid-clear SHALL restart the clear from address 0.
REQ-033 With CLEAR_ON_RESET=0, array contents SHALL survive reset, and ready_o SHALL be 1 in the first cycle after release.
REQ-034 Array storage and the data pipeline registers SHALL have no reset, to allow block-RAM inference.

Structure
REQ-035 Package sc_ram_pkg SHALL hold the FSM state enum (CLEAR, READY) and the constants MIN_READ_LATENCY=1 and MAX_READ_LATENCY=3.
REQ-036 The read valid/data delay line SHALL be sub-module sc_ram_rd_pipe, parameterised by DATA_WIDTH and STAGES.
REQ-037 Illegal parameter values SHALL cause an elaboration-time $error.

Verification
REQ-038 CLEAR_ON_RESET=1, ADDRESS_WIDTH=4: release reset -> ready_o rises exactly 16 cycles later; then reads of addresses 0..15 all return 0x00000000.
REQ-039 Write 0xDEADBEEF to addr 5 with wr_byte_enable_i=4'b1111, then write 0x11223344 with wr_byte_enable_i=4'b0101 -> a read of addr 5 returns 0xDE22BE44.
REQ-040 READ_LATENCY=3, back-to-back reads of addrs 1,2,3 -> rd_valid_o high for 3 consecutive cycles, starting 3 cycles after the first read, with data in order.
REQ-041 Collision on addr 7 (old value 0xAAAAAAAA, write 0x55555555 with all bytes enabled) -> returns 0x55555555 with WRITE_FIRST=1 and 0xAAAAAAAA with WRITE_FIRST=0.
REQ-042 Assert rst_i with 2 reads in flight and clr_cnt=9 -> rd_valid_o stays 0 after release, and the clear reruns for a full 16 cycles.
REQ-043 Reads and writes driven while ready_o=0 -> no rd_valid_o pulse, and memory stays all-zero.
